// File: rtl/uart_frame_rx_if.sv
// Bundle for uart_frame_rx: UART rx FIFO pop side, payload byte stream and frame status.
// The master modport is the deframer; the slave modport is its environment (FIFO, sink, status reader).
interface uart_frame_rx_if #(
  parameter int ADDR_W = 4
);
  logic              rx_empty;
  logic [7:0]        r_data;
  logic              rd_uart;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic [ADDR_W:0]   frame_len;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;

  modport master (
    input  rx_empty, r_data, m_ready,
    output rd_uart, m_data, m_valid, m_last, frame_len, frame_ok, frame_err, err_code
  );

  modport slave (
    output rx_empty, r_data, m_ready,
    input  rd_uart, m_data, m_valid, m_last, frame_len, frame_ok, frame_err, err_code
  );
endinterface

// File: rtl/uart_frame_rx.sv
// SOF-hunting, length-prefixed, checksummed frame receiver; payload released only after the checksum passes.
// Optional inter-byte timeout is compiled in with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_rx #(
  parameter logic [7:0] SOF         = 8'h7E,
  parameter int         MAX_LEN     = 16,
  parameter int         ADDR_W      = 4,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_frame_rx_if.master bus
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

  if (MAX_LEN < 1 || MAX_LEN > DEPTH) begin : g_bad_max_len
    $error("uart_frame_rx: MAX_LEN must lie in 1..2**ADDR_W");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << TO_W)) begin : g_bad_timeout
    $error("uart_frame_rx: TIMEOUT_CYC does not fit the TO_W-bit counter");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic [7:0]      r_buf [DEPTH];
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_wr_cnt;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_frame_len;
  logic [7:0]      r_sum;
  logic [7:0]      r_m_data;
  logic            r_m_valid;
  logic            r_m_last;
  logic            r_frame_ok;
  logic            r_frame_err;
  logic [1:0]      r_err_code;

  logic            w_mid_frame;
  logic            w_pop;
  logic            w_len_bad;
  logic            w_wr_last;
  logic            w_sum_ok;
  logic            w_rd_last;
  logic            w_timeout;
  logic [7:0]      w_byte;
  logic [ADDR_W:0] w_rd_next;

  assign w_byte      = bus.r_data;
  assign w_mid_frame = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  // DRAIN never pops: the UART FIFO absorbs backpressure while the buffer empties.
  assign w_pop       = !reset && !bus.rx_empty && (w_mid_frame || (r_state == S_IDLE));
  assign w_len_bad   = (w_byte == 8'h00) || (w_byte > 8'(MAX_LEN));
  assign w_wr_last   = (r_wr_cnt == r_len - LEN_ONE);
  assign w_sum_ok    = ((r_sum + w_byte) == 8'h00);
  assign w_rd_last   = (r_rd_ptr == r_len - LEN_ONE);
  assign w_rd_next   = r_rd_ptr + LEN_ONE;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // A pop in the expiry cycle wins over the timeout.
  assign w_timeout = w_mid_frame && !w_pop && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (!w_mid_frame || w_pop || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_pop && (r_state == S_DATA)) begin
      r_buf[r_wr_cnt[ADDR_W-1:0]] <= w_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_wr_cnt    <= '0;
      r_rd_ptr    <= '0;
      r_frame_len <= '0;
      r_sum       <= 8'h00;
      r_m_data    <= 8'h00;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop && (w_byte == SOF)) begin
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_pop) begin
            if (w_len_bad) begin
              r_frame_err <= 1'b1;
              r_err_code  <= 2'b01;
              r_state     <= S_IDLE;
            end else begin
              r_len    <= w_byte[ADDR_W:0];
              r_sum    <= w_byte;
              r_wr_cnt <= '0;
              r_state  <= S_DATA;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_code  <= 2'b11;
            r_state     <= S_IDLE;
          end
        end
        S_DATA: begin
          if (w_pop) begin
            r_sum    <= r_sum + w_byte;
            r_wr_cnt <= r_wr_cnt + LEN_ONE;
            if (w_wr_last) begin
              r_state <= S_CHK;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_code  <= 2'b11;
            r_state     <= S_IDLE;
          end
        end
        S_CHK: begin
          if (w_pop) begin
            if (w_sum_ok) begin
              // First payload byte is presented together with the frame_ok pulse.
              r_frame_ok  <= 1'b1;
              r_frame_len <= r_len;
              r_rd_ptr    <= '0;
              r_m_data    <= r_buf[0];
              r_m_last    <= (r_len == LEN_ONE);
              r_m_valid   <= 1'b1;
              r_state     <= S_DRAIN;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= 2'b10;
              r_state     <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_code  <= 2'b11;
            r_state     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (r_m_valid && bus.m_ready) begin
            if (w_rd_last) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_rd_ptr <= w_rd_next;
              r_m_data <= r_buf[w_rd_next[ADDR_W-1:0]];
              r_m_last <= (w_rd_next == r_len - LEN_ONE);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rd_uart   = w_pop;
  assign bus.m_data    = r_m_data;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_last    = r_m_last;
  assign bus.frame_len = r_frame_len;
  assign bus.frame_ok  = r_frame_ok;
  assign bus.frame_err = r_frame_err;
  assign bus.err_code  = r_err_code;
endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Framing/deframing stage directly downstream of the UART receive path.
- Pops bytes from the UART rx FIFO interface (rx_empty / r_data / rd_uart) and hunts for a start-of-frame byte.
- Parses a length-prefixed, checksummed packet and buffers the payload internally.
- Releases the payload on a valid/ready byte stream only after the checksum passes; bad frames are dropped and flagged.

Parameters:
- SOF, 8'h7E, start-of-frame byte.
- MAX_LEN, 16, largest legal payload length in bytes (1..2^ADDR_W).
- ADDR_W, 4, payload buffer address bits; buffer depth = 2^ADDR_W.
- TIMEOUT_CYC, 50000, inter-byte timeout in clk cycles (used only with the optional feature).
- TO_W, 16, timeout counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_empty  in  1  UART rx FIFO empty flag
- r_data  in  8  UART rx FIFO head byte (first-word fall-through)
- rd_uart  out  1  pop strobe to UART rx FIFO
- m_data  out  8  payload byte out
- m_valid  out  1  m_data valid
- m_last  out  1  final payload byte of frame
- m_ready  in  1  downstream accepts byte
- frame_len  out  ADDR_W+1  length of frame being drained
- frame_ok  out  1  one-cycle pulse: checksum good
- frame_err  out  1  one-cycle pulse: frame dropped
- err_code  out  2  last error: 01 bad length, 10 checksum, 11 timeout

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - All outputs 0: m_valid, m_last, frame_ok, frame_err, err_code, frame_len. rd_uart is 0 while reset is asserted.
  - Any partial frame is discarded; buffer contents are don't-care.
- rd_uart (combinational) = !rx_empty && state in {IDLE, LEN, DATA, CHK}. A byte is consumed in the same cycle r_data is sampled.
- rd_uart is never asserted in DRAIN; the UART FIFO absorbs backpressure.
- State machine (one byte per cycle maximum):
  - IDLE: on pop, if byte == SOF go to LEN; otherwise discard silently (no error).
  - LEN: on pop:
    - If byte == 0 or byte > MAX_LEN: frame_err pulse, err_code = 01, go to IDLE.
    - Otherwise: len = byte, sum = byte, wr_cnt = 0, go to DATA.
  - DATA: on pop: buf[wr_cnt] = byte, sum = sum + byte (8-bit, wraps), wr_cnt + 1. When wr_cnt == len-1 on this pop, go to CHK.
  - CHK: on pop:
    - If (sum + byte) mod 256 == 0: frame_ok pulse, frame_len = len, rd_ptr = 0, go to DRAIN.
    - Otherwise: frame_err pulse, err_code = 10, go to IDLE.
  - DRAIN:
    - m_valid = 1, m_data = buf[rd_ptr], m_last = (rd_ptr == len-1).
    - On m_valid && m_ready: rd_ptr + 1.
    - On acceptance of the last byte: m_valid = 0 next cycle, go to IDLE.
- Latency:
  - frame_ok is asserted the cycle after the checksum pop.
  - m_valid is asserted in the same cycle as frame_ok.
- While m_valid is high and m_ready is low, m_data and m_last hold stable.
- A SOF value inside LEN, DATA or CHK is treated as ordinary data; there is no resync mid-frame.
- err_code holds its value until the next frame_err. frame_len holds its value until the next frame_ok.
- frame_ok and frame_err are never asserted in the same cycle.
- Back-to-back frames: the next SOF may be popped in the first IDLE cycle after the last drain handshake.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter runs in LEN, DATA and CHK.
  - It clears on every pop and on entry to IDLE, and holds at 0 in IDLE and DRAIN.
  - If the counter reaches TIMEOUT_CYC-1 with no pop: frame_err pulse, err_code = 11, go to IDLE.
  - If a pop occurs in the same cycle the counter expires, the pop wins and no timeout fires.
- When undefined: no counter exists, the FSM waits indefinitely mid-frame, and err_code 11 is never produced.

Test Plan:
- Good frame: FIFO holds 7E 03 11 22 33 97 -> frame_ok once, frame_len = 3, stream 11, 22, 33 with m_last only on 33, err_code stays 00.
- Noise before frame: 00 FF 7E 01 A5 5A -> 00 and FF silently dropped, no frame_err, single output byte A5 with m_last = 1.
- Bad checksum: 7E 02 10 20 00 -> frame_err, err_code = 10, m_valid never asserted. A following 7E 01 A5 5A is delivered normally.
- Bad length: 7E 00, then 7E 11 (17 > MAX_LEN) -> two frame_err pulses, err_code = 01. The byte after each bad length is treated as an SOF hunt.
- Backpressure: good 3-byte frame plus a second frame queued in FIFO, m_ready low 5 cycles mid-drain -> rd_uart = 0 throughout DRAIN, m_data/m_last stable, second frame parsed only after the last handshake.
- Timeout (macro defined, TIMEOUT_CYC = 100): 7E 04 01 then FIFO empty for 100 cycles -> frame_err, err_code = 11, IDLE. With macro undefined, the FSM stays in DATA and completes when the remaining bytes arrive.
